bram_mux_arb: RTL



---
 rtl/bram_mux_pkg.sv | 12 +
 rtl/bram_rr_arb.sv | 30 +++
 rtl/bram_mux_arb.sv | 124 ++++++++++++
 3 files changed

// File: rtl/bram_mux_pkg.sv
// bram_mux_pkg: shared constants, bank-id width helper and return-pipeline entry for bram_mux_arb
package bram_mux_pkg;
   localparam int STALL_CNT_WIDTH = 32;
   localparam int BANK_ID_MAX = 8;
   function automatic int bank_id_width(input int nb_brams);
      return (nb_brams > 1) ? $clog2(nb_brams) : 0;
   endfunction
   typedef struct packed {
      logic                   valid;
      logic [BANK_ID_MAX-1:0] bank;
   } ret_entry_t;
endpackage

// File: rtl/bram_rr_arb.sv
// bram_rr_arb: round-robin arbiter, one-hot grant searched from a registered pointer
module bram_rr_arb #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   logic [PW-1:0] ptr, ptr_nxt, idx;
   logic found;
   always_comb begin
      gnt = '0;
      ptr_nxt = ptr;
      found = 1'b0;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         idx = PW'((int'(ptr) + i) % N);
         if (!found && req[idx]) begin
            found = 1'b1;
            gnt[idx] = 1'b1;
            ptr_nxt = PW'((int'(idx) + 1) % N);
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr <= '0;
      else ptr <= ptr_nxt;
endmodule

// File: rtl/bram_mux_arb.sv
// bram_mux_arb: NB_PORTS owners share NB_BRAMS BRAM banks via per-bank round-robin arbiters.
// Define BRAM_MUX_ARB_PERF_EN to build the per-port saturating stall counters.
module bram_mux_arb
   import bram_mux_pkg::*;
#(
   parameter int NB_BRAMS = 2,
   parameter int NB_PORTS = 2,
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 512,
   parameter int BRAM_RD_LAT = 1,
   parameter int BANK_SEL_LSB = 1,
   localparam int BID = bank_id_width(NB_BRAMS),
   localparam int IAW = ADDR_WIDTH + BID
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic [NB_PORTS-1:0][IAW-1:0]                  in_addr,
   input  logic [NB_PORTS-1:0][DATA_WIDTH-1:0]           in_wr_data,
   input  logic [NB_PORTS-1:0]                           in_rd_en,
   input  logic [NB_PORTS-1:0]                           in_wr_en,
   output logic [NB_PORTS-1:0]                           in_ready,
   output logic [NB_PORTS-1:0][DATA_WIDTH-1:0]           in_rd_data,
   output logic [NB_PORTS-1:0]                           in_rd_valid,
   output logic [NB_BRAMS-1:0][ADDR_WIDTH-1:0]           out_addr,
   output logic [NB_BRAMS-1:0][DATA_WIDTH-1:0]           out_wr_data,
   output logic [NB_BRAMS-1:0]                           out_rd_en,
   output logic [NB_BRAMS-1:0]                           out_wr_en,
   input  logic [NB_BRAMS-1:0][DATA_WIDTH-1:0]           out_rd_data,
   output logic [NB_PORTS-1:0][STALL_CNT_WIDTH-1:0]      stall_cnt
);
   localparam int D = 1 + BRAM_RD_LAT;
   logic [NB_PORTS-1:0] p_req;
   logic [NB_PORTS-1:0][BANK_ID_MAX-1:0] p_bank;
   logic [NB_PORTS-1:0][ADDR_WIDTH-1:0] p_baddr;
   logic [NB_BRAMS-1:0][NB_PORTS-1:0] b_req, b_gnt;
   logic [NB_BRAMS-1:0] b_any, b_rd, b_wr;
   logic [NB_BRAMS-1:0][ADDR_WIDTH-1:0] b_addr;
   logic [NB_BRAMS-1:0][DATA_WIDTH-1:0] b_data;
   ret_entry_t pipe [NB_PORTS][D];
   for (genvar p = 0; p < NB_PORTS; p++) begin : g_dec
      assign p_req[p] = in_rd_en[p] | in_wr_en[p];
      if (NB_BRAMS == 1) begin : g_one
         assign p_bank[p] = '0;
         assign p_baddr[p] = in_addr[p];
      end else if (BANK_SEL_LSB != 0) begin : g_lsb
         assign p_bank[p] = BANK_ID_MAX'(in_addr[p][BID-1:0]);
         assign p_baddr[p] = in_addr[p][BID +: ADDR_WIDTH];
      end else begin : g_msb
         assign p_bank[p] = BANK_ID_MAX'(in_addr[p][IAW-1 -: BID]);
         assign p_baddr[p] = in_addr[p][ADDR_WIDTH-1:0];
      end
   end
   always_comb begin
      b_req = '0;
      for (int b = 0; b < NB_BRAMS; b++)
         for (int p = 0; p < NB_PORTS; p++)
            b_req[b][p] = p_req[p] && (p_bank[p] == BANK_ID_MAX'(b));
   end
   for (genvar b = 0; b < NB_BRAMS; b++) begin : g_bank
      bram_rr_arb #(.N(NB_PORTS)) u_arb (.clk(clk), .rst_n(rst_n), .req(b_req[b]), .gnt(b_gnt[b]));
   end
   // each port targets exactly one bank, so at most one grant per port is set
   always_comb begin
      in_ready = '0;
      b_any = '0;
      b_rd = '0;
      b_wr = '0;
      b_addr = '0;
      b_data = '0;
      for (int b = 0; b < NB_BRAMS; b++)
         for (int p = 0; p < NB_PORTS; p++)
            if (b_gnt[b][p]) begin
               in_ready[p] = rst_n;
               b_any[b] = 1'b1;
               b_rd[b] = in_rd_en[p];
               b_wr[b] = in_wr_en[p];
               b_addr[b] = p_baddr[p];
               b_data[b] = in_wr_data[p];
            end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_rd_en <= '0;
         out_wr_en <= '0;
         out_addr <= '0;
         out_wr_data <= '0;
      end else begin
         out_rd_en <= b_rd;
         out_wr_en <= b_wr;
         for (int b = 0; b < NB_BRAMS; b++)
            if (b_any[b]) begin
               out_addr[b] <= b_addr[b];
               out_wr_data[b] <= b_data[b];
            end
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int p = 0; p < NB_PORTS; p++)
            for (int d = 0; d < D; d++)
               pipe[p][d] <= '0;
         in_rd_valid <= '0;
         in_rd_data <= '0;
      end else begin
         for (int p = 0; p < NB_PORTS; p++) begin
            pipe[p][0] <= '{valid: in_ready[p] & in_rd_en[p], bank: p_bank[p]};
            for (int d = 1; d < D; d++)
               pipe[p][d] <= pipe[p][d-1];
            in_rd_valid[p] <= pipe[p][D-1].valid;
            for (int b = 0; b < NB_BRAMS; b++)
               if (pipe[p][D-1].valid && pipe[p][D-1].bank == BANK_ID_MAX'(b))
                  in_rd_data[p] <= out_rd_data[b];
         end
      end
`ifdef BRAM_MUX_ARB_PERF_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) stall_cnt <= '0;
      else
         for (int p = 0; p < NB_PORTS; p++)
            if (p_req[p] && !in_ready[p] && stall_cnt[p] != '1)
               stall_cnt[p] <= stall_cnt[p] + 1'b1;
`else
   assign stall_cnt = '0;
`endif
endmodule
